bsg_mcl_request_scheduler: RTL and testbench



---
 rtl/bsg_mcl_request_scheduler.sv | 102 ++++++++++
 tb/tb_bsg_mcl_request_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mcl_request_scheduler.sv
// Round-robin scheduler sharing one manycore endpoint request channel among
// num_req_p host request FIFOs, with credit-aware grant gating.
module bsg_mcl_request_scheduler #(
  parameter  int num_req_p         = 4,
  parameter  int fifo_width_p      = 128,
  parameter  int max_out_credits_p = 16,
  localparam int credits_width_lp  = $clog2(max_out_credits_p + 1),
  localparam int id_width_lp       = $clog2(num_req_p)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic                                    en_i,
  input  logic [num_req_p-1:0]                    req_v_i,
  input  logic [num_req_p-1:0][fifo_width_p-1:0]  req_data_i,
  output logic [num_req_p-1:0]                    req_yumi_o,
  output logic                                    out_v_o,
  output logic [fifo_width_p-1:0]                 out_data_o,
  input  logic                                    out_rdy_i,
  input  logic [credits_width_lp-1:0]             out_credits_i,
  output logic [id_width_lp-1:0]                  grant_id_o,
  output logic [31:0]                             grant_cnt_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                    state_r;
  logic [fifo_width_p-1:0]   data_r;
  logic [id_width_lp-1:0]    id_r;
  logic [id_width_lp-1:0]    last_r;
  logic                      hs_r;
  logic [31:0]               cnt_r;

  logic                      hs;
  logic                      can_load;
  logic                      credit_ok;
  logic                      grant_v;
  logic                      found;
  logic [id_width_lp-1:0]    winner;
  int                        cand;
  logic [credits_width_lp:0] inflight;

  assign out_v_o     = (state_r == FULL);
  assign out_data_o  = data_r;
  assign grant_id_o  = id_r;
  assign grant_cnt_o = cnt_r;

  assign hs       = out_v_o & out_rdy_i;
  assign can_load = (state_r == EMPTY) | hs;

  // Credits drop one cycle after acceptance, so both the send happening now
  // and the one accepted last cycle must still be covered by the count.
  assign inflight  = {{credits_width_lp{1'b0}}, hs} + {{credits_width_lp{1'b0}}, hs_r};
  assign credit_ok = {1'b0, out_credits_i} > inflight;

  // Scan starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    winner = last_r;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= num_req_p; k++) begin
      cand = (int'(last_r) + k) % num_req_p;
      if (!found && req_v_i[cand]) begin
        found  = 1'b1;
        winner = id_width_lp'(cand);
      end
    end
  end

  assign grant_v = reset_n_i & en_i & can_load & credit_ok & found;

  always_comb begin
    req_yumi_o = '0;
    if (grant_v) req_yumi_o[winner] = 1'b1;
  end

  // Output register stage: EMPTY/FULL is the only control state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= EMPTY;
      data_r  <= '0;
      id_r    <= '0;
      last_r  <= id_width_lp'(num_req_p - 1);
      hs_r    <= 1'b0;
      cnt_r   <= '0;
    end else begin
      hs_r <= hs;
      if (hs) cnt_r <= cnt_r + 32'd1;
      if (grant_v) begin
        state_r <= FULL;
        data_r  <= req_data_i[winner];
        id_r    <= winner;
        last_r  <= winner;
      end else if (hs) begin
        state_r <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_bsg_mcl_request_scheduler.sv
// Directed scoreboard bench for bsg_mcl_request_scheduler: grants, round-robin
// order, credit gating, backpressure, pause, async reset and counter wrap.
module tb_bsg_mcl_request_scheduler;

  localparam int N  = 4;
  localparam int W  = 128;
  localparam int MC = 16;
  localparam int CW = $clog2(MC + 1);
  localparam int IW = $clog2(N);

  logic                 clk      = 1'b0;
  logic                 reset_n  = 1'b0;
  logic                 en       = 1'b0;
  logic [N-1:0]         req_v    = '0;
  logic [N-1:0][W-1:0]  req_data;
  logic [N-1:0]         yumi;
  logic                 out_v;
  logic [W-1:0]         out_data;
  logic                 out_rdy  = 1'b0;
  logic [CW-1:0]        credits  = '0;
  logic [IW-1:0]        gid;
  logic [31:0]          gcnt;

  bsg_mcl_request_scheduler #(
    .num_req_p(N), .fifo_width_p(W), .max_out_credits_p(MC)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en),
    .req_v_i(req_v), .req_data_i(req_data), .req_yumi_o(yumi),
    .out_v_o(out_v), .out_data_o(out_data), .out_rdy_i(out_rdy),
    .out_credits_i(credits), .grant_id_o(gid), .grant_cnt_o(gcnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } word_t;

  int            total = 0;
  int            bad   = 0;
  word_t         sb[$];
  logic [IW-1:0] id_log[$];
  logic          m_v;
  logic [IW-1:0] m_last;
  logic          m_hs_r;
  logic [31:0]   m_cnt;
  logic [N-1:0]  last_yumi;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_v    = 1'b0;
    m_last = IW'(N - 1);
    m_hs_r = 1'b0;
    m_cnt  = '0;
    sb.delete();
  endtask

  // One clock: check combinational yumi and the held word, advance the model,
  // cross the edge, then check the registered state.
  task automatic tick();
    int           w;
    logic         hs, cok, gv;
    logic [N-1:0] exp_yumi;
    #1;
    hs  = m_v & out_rdy;
    cok = int'(credits) > (int'(hs) + int'(m_hs_r));
    w   = rr_pick(int'(m_last), req_v);
    gv  = en & (!m_v | hs) & cok & (w >= 0);
    exp_yumi = '0;
    if (gv) exp_yumi[w] = 1'b1;
    last_yumi = yumi;
    chk("yumi", W'(yumi), W'(exp_yumi));
    if (m_v) begin
      chk("sb_depth", W'(sb.size()), W'(1));
      if (sb.size() > 0) begin
        chk("held_data", out_data, sb[0].data);
        chk("held_id", W'(gid), W'(sb[0].id));
      end
    end
    if (hs) begin
      id_log.push_back(gid);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    if (gv) sb.push_back({IW'(w), req_data[w]});
    m_cnt  = m_cnt + (hs ? 32'd1 : 32'd0);
    m_hs_r = hs;
    if (gv) begin
      m_v    = 1'b1;
      m_last = IW'(w);
    end else if (hs) begin
      m_v = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_v", W'(out_v), W'(m_v));
    chk("grant_cnt", W'(gcnt), W'(m_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) req_data[i] = {8{16'hB000 | 16'(i)}};
    model_reset();
    last_yumi = '0;

    // Reset state, with a live request that must not be dequeued
    en    = 1'b1;
    req_v = 4'b0001;
    #12;
    chk("rst_out_v", W'(out_v), W'(0));
    chk("rst_data", out_data, W'(0));
    chk("rst_id", W'(gid), W'(0));
    chk("rst_cnt", W'(gcnt), W'(0));
    chk("rst_yumi", W'(yumi), W'(0));
    req_v = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single word
    credits     = CW'(16);
    req_data[0] = {16{8'hA5}};
    req_v       = 4'b0001;
    tick();
    chk("single_yumi", W'(last_yumi), W'(4'b0001));
    req_v = '0;
    chk("single_data", out_data, {16{8'hA5}});
    chk("single_id", W'(gid), W'(0));
    out_rdy = 1'b1;
    tick();
    chk("single_cnt", W'(gcnt), W'(1));
    out_rdy = 1'b0;
    req_data[0] = {8{16'hB000}};

    // Round-robin from a fresh reset
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    id_log.delete();
    req_v   = 4'b1111;
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    req_v = '0;
    tick();
    chk("rr_len", W'(id_log.size()), W'(6));
    if (id_log.size() >= 5) begin
      chk("rr_0", W'(id_log[0]), W'(0));
      chk("rr_1", W'(id_log[1]), W'(1));
      chk("rr_2", W'(id_log[2]), W'(2));
      chk("rr_3", W'(id_log[3]), W'(3));
      chk("rr_4", W'(id_log[4]), W'(0));
    end
    tick();

    // Credit gate: one credit, lagging decrement
    credits = CW'(1);
    req_v   = 4'b0101;
    tick();
    chk("cg_first", W'(last_yumi), W'(4'b0100));
    req_v = 4'b0001;
    tick();
    chk("cg_hs_block", W'(last_yumi), W'(0));
    tick();
    chk("cg_lag_block", W'(last_yumi), W'(0));
    credits = CW'(0);
    tick();
    chk("cg_zero_block", W'(last_yumi), W'(0));
    credits = CW'(1);
    tick();
    chk("cg_return", W'(last_yumi), W'(4'b0001));
    req_v = '0;
    tick();
    tick();

    // Backpressure then back-to-back transfer
    credits = CW'(8);
    out_rdy = 1'b0;
    req_v   = 4'b0010;
    tick();
    req_v = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_yumi", W'(last_yumi), W'(0));
      chk("bp_data", out_data, {8{16'hB001}});
    end
    out_rdy = 1'b1;
    tick();
    chk("b2b_yumi", W'(last_yumi), W'(4'b1000));
    req_v = '0;
    chk("b2b_id", W'(gid), W'(3));
    chk("b2b_v", W'(out_v), W'(1));

    // Pause: held word drains, nothing new granted
    en    = 1'b0;
    req_v = 4'b0001;
    tick();
    chk("pause_yumi", W'(last_yumi), W'(0));
    tick();
    chk("pause_empty", W'(out_v), W'(0));

    // Asynchronous reset while FULL
    en      = 1'b1;
    out_rdy = 1'b0;
    tick();
    req_v = 4'b0100;
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_v", W'(out_v), W'(0));
    chk("arst_cnt", W'(gcnt), W'(0));
    chk("arst_yumi", W'(yumi), W'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    req_v   = 4'b0101;
    tick();
    chk("arst_first", W'(last_yumi), W'(4'b0001));
    req_v   = 4'b0100;
    out_rdy = 1'b1;
    tick();
    req_v = '0;
    tick();

    // Counter wrap
    out_rdy = 1'b0;
    req_v   = 4'b0001;
    tick();
    req_v = '0;
    force dut.cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_r;
    m_cnt = 32'hFFFF_FFFF;
    out_rdy = 1'b1;
    tick();
    chk("wrap", W'(gcnt), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
